// File: rtl/axi_id_remapper_if.sv
// AXI channel bundle used on both sides of the ID remapper.
// The master-side and slave-side instances differ only in ID_WIDTH.
interface axi_channel #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned USER_WIDTH = 1
);
  logic                    aw_valid;
  logic                    aw_ready;
  logic [ID_WIDTH-1:0]     aw_id;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]              aw_len;
  logic [2:0]              aw_size;
  logic [1:0]              aw_burst;
  logic [USER_WIDTH-1:0]   aw_user;

  logic                    w_valid;
  logic                    w_ready;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_last;
  logic [USER_WIDTH-1:0]   w_user;

  logic                    b_valid;
  logic                    b_ready;
  logic [ID_WIDTH-1:0]     b_id;
  logic [1:0]              b_resp;
  logic [USER_WIDTH-1:0]   b_user;

  logic                    ar_valid;
  logic                    ar_ready;
  logic [ID_WIDTH-1:0]     ar_id;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]              ar_len;
  logic [2:0]              ar_size;
  logic [1:0]              ar_burst;
  logic [USER_WIDTH-1:0]   ar_user;

  logic                    r_valid;
  logic                    r_ready;
  logic [ID_WIDTH-1:0]     r_id;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  logic                    r_last;
  logic [USER_WIDTH-1:0]   r_user;

  modport master (
    output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_user,
    input  aw_ready,
    output w_valid, w_data, w_strb, w_last, w_user,
    input  w_ready,
    input  b_valid, b_id, b_resp, b_user,
    output b_ready,
    output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_user,
    input  ar_ready,
    input  r_valid, r_id, r_data, r_resp, r_last, r_user,
    output r_ready
  );

  modport slave (
    input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_user,
    output aw_ready,
    input  w_valid, w_data, w_strb, w_last, w_user,
    output w_ready,
    output b_valid, b_id, b_resp, b_user,
    input  b_ready,
    input  ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_user,
    output ar_ready,
    output r_valid, r_id, r_data, r_resp, r_last, r_user,
    input  r_ready
  );
endinterface

// File: rtl/axi_id_remapper.sv
// Wide-to-narrow AXI ID remapper: each in-flight master ID is dynamically bound
// to a free slave ID and the full master ID is restored on B/R responses.
module axi_id_remapper_engine #(
  parameter int unsigned MID = 6,
  parameter int unsigned SID = 2,
  parameter int unsigned CW  = 4,
  parameter int unsigned PW  = 1
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [MID-1:0] req_id,
  input  logic [PW-1:0]  req_pl,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [SID-1:0] out_id,
  output logic [PW-1:0]  out_pl,
  input  logic           rsp_hs,
  input  logic           rsp_last,
  input  logic [SID-1:0] rsp_sid,
  output logic [MID-1:0] rsp_mid
);
  localparam int unsigned   NENT    = 1 << SID;
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic           stg_valid;
  logic [MID-1:0] stg_id;
  logic [PW-1:0]  stg_pl;
  logic [MID-1:0] mid_q [NENT];
  logic [CW-1:0]  cnt_q [NENT];

  logic           hit;
  logic           free_found;
  logic           grant;
  logic [SID-1:0] hit_idx;
  logic [SID-1:0] free_idx;
  logic [SID-1:0] grant_idx;
  logic           out_fire;
  logic [NENT-1:0] inc;
  logic [NENT-1:0] dec;

  // A live entry for the same ID always wins over a free one so that same-ID
  // transactions stay on one slave ID and keep their AXI ordering.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int unsigned i = 0; i < NENT; i++) begin
      if (cnt_q[i] != '0 && mid_q[i] == stg_id) begin
        hit     = 1'b1;
        hit_idx = SID'(i);
      end
    end
    for (int unsigned i = NENT; i > 0; i--) begin
      if (cnt_q[i-1] == '0) begin
        free_found = 1'b1;
        free_idx   = SID'(i-1);
      end
    end
    grant_idx = hit ? hit_idx : free_idx;
    grant     = hit ? (cnt_q[hit_idx] != CNT_MAX) : free_found;
  end

  assign out_valid = stg_valid && grant;
  assign out_id    = grant_idx;
  assign out_pl    = stg_pl;
  assign out_fire  = out_valid && out_ready;
  assign req_ready = !stg_valid || out_fire;
  assign rsp_mid   = mid_q[rsp_sid];

  always_comb begin
    inc = '0;
    dec = '0;
    for (int unsigned i = 0; i < NENT; i++) begin
      inc[i] = out_fire && (grant_idx == SID'(i));
      dec[i] = rsp_hs && rsp_last && (rsp_sid == SID'(i)) && (cnt_q[i] != '0);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stg_valid <= 1'b0;
      stg_id    <= '0;
      stg_pl    <= '0;
    end else if (req_valid && req_ready) begin
      stg_valid <= 1'b1;
      stg_id    <= req_id;
      stg_pl    <= req_pl;
    end else if (out_fire) begin
      stg_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < NENT; i++) begin
        mid_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NENT; i++) begin
        if (inc[i]) mid_q[i] <= stg_id;
        if (inc[i] && !dec[i]) cnt_q[i] <= cnt_q[i] + 1'b1;
        else if (dec[i] && !inc[i]) cnt_q[i] <= cnt_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && rsp_hs)
      assert (cnt_q[rsp_sid] != '0) else $error("response on idle slave ID %0d", rsp_sid);
  end
endmodule

module axi_id_remapper #(
  parameter int unsigned ACTIVE_CNT_WIDTH = 4
) (
  input logic        clk,
  input logic        rstn,
  axi_channel.slave  master,
  axi_channel.master slave
);
  localparam int unsigned MID = master.ID_WIDTH;
  localparam int unsigned SID = slave.ID_WIDTH;
  localparam int unsigned AW  = master.ADDR_WIDTH;
  localparam int unsigned UW  = master.USER_WIDTH;
  localparam int unsigned PW  = AW + 8 + 3 + 2 + UW;

  if (master.DATA_WIDTH != slave.DATA_WIDTH || master.ADDR_WIDTH != slave.ADDR_WIDTH ||
      master.USER_WIDTH != slave.USER_WIDTH || MID <= SID) begin : g_param_check
    $fatal(1, "Parameter mismatch");
  end

  logic [PW-1:0] aw_req_pl;
  logic [PW-1:0] aw_out_pl;
  logic [PW-1:0] ar_req_pl;
  logic [PW-1:0] ar_out_pl;

  assign aw_req_pl = {master.aw_addr, master.aw_len, master.aw_size, master.aw_burst, master.aw_user};
  assign {slave.aw_addr, slave.aw_len, slave.aw_size, slave.aw_burst, slave.aw_user} = aw_out_pl;
  assign ar_req_pl = {master.ar_addr, master.ar_len, master.ar_size, master.ar_burst, master.ar_user};
  assign {slave.ar_addr, slave.ar_len, slave.ar_size, slave.ar_burst, slave.ar_user} = ar_out_pl;

  axi_id_remapper_engine #(
    .MID (MID),
    .SID (SID),
    .CW  (ACTIVE_CNT_WIDTH),
    .PW  (PW)
  ) u_wr (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (master.aw_valid),
    .req_ready (master.aw_ready),
    .req_id    (master.aw_id),
    .req_pl    (aw_req_pl),
    .out_valid (slave.aw_valid),
    .out_ready (slave.aw_ready),
    .out_id    (slave.aw_id),
    .out_pl    (aw_out_pl),
    .rsp_hs    (slave.b_valid && master.b_ready),
    .rsp_last  (1'b1),
    .rsp_sid   (slave.b_id),
    .rsp_mid   (master.b_id)
  );

  // Read entries are held for the whole burst and released on the last beat.
  axi_id_remapper_engine #(
    .MID (MID),
    .SID (SID),
    .CW  (ACTIVE_CNT_WIDTH),
    .PW  (PW)
  ) u_rd (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (master.ar_valid),
    .req_ready (master.ar_ready),
    .req_id    (master.ar_id),
    .req_pl    (ar_req_pl),
    .out_valid (slave.ar_valid),
    .out_ready (slave.ar_ready),
    .out_id    (slave.ar_id),
    .out_pl    (ar_out_pl),
    .rsp_hs    (slave.r_valid && master.r_ready),
    .rsp_last  (slave.r_last),
    .rsp_sid   (slave.r_id),
    .rsp_mid   (master.r_id)
  );

  assign slave.w_valid  = master.w_valid;
  assign slave.w_data   = master.w_data;
  assign slave.w_strb   = master.w_strb;
  assign slave.w_last   = master.w_last;
  assign slave.w_user   = master.w_user;
  assign master.w_ready = slave.w_ready;

  assign master.b_valid = slave.b_valid;
  assign master.b_resp  = slave.b_resp;
  assign master.b_user  = slave.b_user;
  assign slave.b_ready  = master.b_ready;

  assign master.r_valid = slave.r_valid;
  assign master.r_data  = slave.r_data;
  assign master.r_resp  = slave.r_resp;
  assign master.r_last  = slave.r_last;
  assign master.r_user  = slave.r_user;
  assign slave.r_ready  = master.r_ready;
endmodule

// File: tb/tb_axi_id_remapper.sv
// Bench for axi_id_remapper: cycle tables for the write corner cases, hand
// sequences for read release and reset, and a random run against a queue model.
module tb_axi_id_remapper;
  logic clk;
  logic rstn;
  int   checks;
  int   failures;

  axi_channel #(.ID_WIDTH(6), .ADDR_WIDTH(16), .DATA_WIDTH(16), .USER_WIDTH(2)) m_if ();
  axi_channel #(.ID_WIDTH(2), .ADDR_WIDTH(16), .DATA_WIDTH(16), .USER_WIDTH(2)) s_if ();

  axi_id_remapper #(.ACTIVE_CNT_WIDTH(2)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .master (m_if.slave),
    .slave  (s_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic       awv;
    logic [5:0] awid;
    logic       bv;
    logic [1:0] bsid;
    logic       e_awr;
    logic       e_sv;
    logic [1:0] e_sid;
    logic [5:0] e_bid;
  } vec_t;

  typedef struct packed {
    logic [5:0] mid;
    logic [1:0] sid;
  } ot_t;

  vec_t vecs[$];
  ot_t  out_q[$];

  function automatic vec_t mk(input int awv, input int awid, input int bv, input int bsid,
                              input int e_awr, input int e_sv, input int e_sid, input int e_bid);
    vec_t r;
    r.awv   = 1'(awv);
    r.awid  = 6'(awid);
    r.bv    = 1'(bv);
    r.bsid  = 2'(bsid);
    r.e_awr = 1'(e_awr);
    r.e_sv  = 1'(e_sv);
    r.e_sid = 2'(e_sid);
    r.e_bid = 6'(e_bid);
    return r;
  endfunction

  function automatic logic sid_busy(input logic [1:0] s);
    foreach (out_q[j]) if (out_q[j].sid == s) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    m_if.aw_valid = 1'b0; m_if.aw_id = '0; m_if.aw_addr = '0; m_if.aw_len = '0;
    m_if.aw_size = '0; m_if.aw_burst = '0; m_if.aw_user = '0;
    m_if.w_valid = 1'b0; m_if.w_data = '0; m_if.w_strb = '0; m_if.w_last = 1'b0; m_if.w_user = '0;
    m_if.b_ready = 1'b1;
    m_if.ar_valid = 1'b0; m_if.ar_id = '0; m_if.ar_addr = '0; m_if.ar_len = '0;
    m_if.ar_size = '0; m_if.ar_burst = '0; m_if.ar_user = '0;
    m_if.r_ready = 1'b1;
    s_if.aw_ready = 1'b1; s_if.w_ready = 1'b0; s_if.ar_ready = 1'b1;
    s_if.b_valid = 1'b0; s_if.b_id = '0; s_if.b_resp = '0; s_if.b_user = '0;
    s_if.r_valid = 1'b0; s_if.r_id = '0; s_if.r_data = '0; s_if.r_resp = '0;
    s_if.r_last = 1'b0; s_if.r_user = '0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    clear_inputs();
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic random_phase(input int unsigned cycles);
    logic [5:0]  pool [6];
    logic        pend_v, hold, bv, e_v, e_awr;
    logic [5:0]  pend_id, e_bid;
    logic [15:0] pend_addr;
    logic [1:0]  e_sid, bsid;
    int          same, k;
    ot_t         item;
    pool = '{6'h00, 6'h01, 6'h11, 6'h21, 6'h31, 6'h3F};
    pend_v = 1'b0; pend_id = '0; pend_addr = '0; hold = 1'b0;
    out_q.delete();
    for (int unsigned c = 0; c < cycles; c++) begin
      if (!hold) begin
        m_if.aw_valid = ($urandom_range(0, 3) != 0);
        m_if.aw_id    = pool[$urandom_range(0, 5)];
        m_if.aw_addr  = 16'($urandom);
      end
      s_if.aw_ready = ($urandom_range(0, 3) != 0);
      m_if.b_ready  = ($urandom_range(0, 3) != 0);
      bv = 1'b0; bsid = '0; e_bid = '0;
      if (out_q.size() != 0 && $urandom_range(0, 2) == 0) begin
        k     = int'($urandom_range(0, out_q.size() - 1));
        bv    = 1'b1;
        bsid  = out_q[k].sid;
        e_bid = out_q[k].mid;
      end
      s_if.b_valid = bv;
      s_if.b_id    = bsid;
      s_if.b_resp  = 2'($urandom);

      e_v = 1'b0; e_sid = '0; same = 0;
      if (pend_v) begin
        foreach (out_q[j]) if (out_q[j].mid == pend_id) begin same++; e_sid = out_q[j].sid; end
        if (same > 0) e_v = (same < 3);
        else for (int s = 0; s < 4 && !e_v; s++) if (!sid_busy(2'(s))) begin e_v = 1'b1; e_sid = 2'(s); end
      end
      e_awr = !pend_v || (e_v && s_if.aw_ready);

      #1;
      chk("rnd m.aw_ready", 32'(m_if.aw_ready), 32'(e_awr));
      chk("rnd s.aw_valid", 32'(s_if.aw_valid), 32'(e_v));
      if (e_v) begin
        chk("rnd s.aw_id", 32'(s_if.aw_id), 32'(e_sid));
        chk("rnd s.aw_addr", 32'(s_if.aw_addr), 32'(pend_addr));
      end
      if (bv) begin
        chk("rnd m.b_id", 32'(m_if.b_id), 32'(e_bid));
        chk("rnd m.b_resp", 32'(m_if.b_resp), 32'(s_if.b_resp));
      end

      if (bv && m_if.b_ready) begin
        for (int j = 0; j < out_q.size(); j++) begin
          if (out_q[j].sid == bsid) begin
            out_q.delete(j);
            break;
          end
        end
      end
      if (e_v && s_if.aw_ready) begin
        item.mid = pend_id;
        item.sid = e_sid;
        out_q.push_back(item);
      end
      if (m_if.aw_valid && e_awr) begin
        pend_v = 1'b1; pend_id = m_if.aw_id; pend_addr = m_if.aw_addr;
      end else if (e_v && s_if.aw_ready) begin
        pend_v = 1'b0;
      end
      hold = m_if.aw_valid && !e_awr;
      tick();
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rstn = 1'b0;
    clear_inputs();
    m_if.w_data = 16'hA5C3;
    s_if.w_ready = 1'b1;
    #3;
    chk("reset m.aw_ready", 32'(m_if.aw_ready), 32'd1);
    chk("reset m.ar_ready", 32'(m_if.ar_ready), 32'd1);
    chk("reset s.aw_valid", 32'(s_if.aw_valid), 32'd0);
    chk("reset s.ar_valid", 32'(s_if.ar_valid), 32'd0);
    chk("reset w_data pass", 32'(s_if.w_data), 32'hA5C3);
    chk("reset w_ready pass", 32'(m_if.w_ready), 32'd1);
    do_reset();

    // distinct ids; fifth stalls until slave id 0 is released
    vecs.push_back(mk(1, 'h00, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 'h04, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 'h08, 0, 0, 1, 1, 1, 0));
    vecs.push_back(mk(1, 'h0C, 0, 0, 1, 1, 2, 0));
    vecs.push_back(mk(1, 'h10, 0, 0, 1, 1, 3, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 'h00));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0, 'h10));
    vecs.push_back(mk(0, 0, 1, 2, 1, 0, 0, 'h08));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0, 'h04));
    vecs.push_back(mk(0, 0, 1, 3, 1, 0, 0, 'h0C));
    // same id saturates its entry while others are free
    vecs.push_back(mk(1, 'h21, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 'h21, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 'h21, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 'h21, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 'h21));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0, 'h21));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0, 'h21));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0, 'h21));
    // issue and release on the same entry in one cycle
    vecs.push_back(mk(1, 'h05, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 'h05, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 1, 0, 'h05));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0, 'h05));
    vecs.push_back(mk(1, 'h2A, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0, 'h2A));
    // out-of-order responses
    vecs.push_back(mk(1, 'h01, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 'h02, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0, 'h02));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0, 'h01));

    foreach (vecs[k]) begin
      m_if.aw_valid = vecs[k].awv;
      m_if.aw_id    = vecs[k].awid;
      m_if.aw_addr  = {10'd0, vecs[k].awid};
      s_if.b_valid  = vecs[k].bv;
      s_if.b_id     = vecs[k].bsid;
      #1;
      chk($sformatf("vec%0d m.aw_ready", k), 32'(m_if.aw_ready), 32'(vecs[k].e_awr));
      chk($sformatf("vec%0d s.aw_valid", k), 32'(s_if.aw_valid), 32'(vecs[k].e_sv));
      if (vecs[k].e_sv) chk($sformatf("vec%0d s.aw_id", k), 32'(s_if.aw_id), 32'(vecs[k].e_sid));
      if (vecs[k].bv) chk($sformatf("vec%0d m.b_id", k), 32'(m_if.b_id), 32'(vecs[k].e_bid));
      tick();
    end
    clear_inputs();

    // read burst: only the last beat frees the entry
    m_if.ar_valid = 1'b1; m_if.ar_id = 6'h15; m_if.ar_len = 8'd3;
    #1 chk("rd ar_ready", 32'(m_if.ar_ready), 32'd1);
    tick();
    m_if.ar_valid = 1'b0;
    #1;
    chk("rd s.ar_valid", 32'(s_if.ar_valid), 32'd1);
    chk("rd s.ar_id", 32'(s_if.ar_id), 32'd0);
    chk("rd s.ar_len", 32'(s_if.ar_len), 32'd3);
    tick();
    for (int b = 0; b < 3; b++) begin
      s_if.r_valid = 1'b1; s_if.r_id = 2'd0; s_if.r_last = 1'b0;
      #1 chk($sformatf("rd beat%0d r_id", b), 32'(m_if.r_id), 32'h15);
      tick();
    end
    s_if.r_valid = 1'b0;
    m_if.ar_valid = 1'b1; m_if.ar_id = 6'h2A;
    tick();
    m_if.ar_valid = 1'b0;
    #1 chk("rd busy probe ar_id", 32'(s_if.ar_id), 32'd1);
    tick();
    s_if.r_valid = 1'b1; s_if.r_id = 2'd1; s_if.r_last = 1'b1;
    #1 chk("rd probe last r_id", 32'(m_if.r_id), 32'h2A);
    tick();
    s_if.r_id = 2'd0;
    #1 chk("rd last r_id", 32'(m_if.r_id), 32'h15);
    tick();
    s_if.r_valid = 1'b0;
    m_if.ar_valid = 1'b1; m_if.ar_id = 6'h2A;
    tick();
    m_if.ar_valid = 1'b0;
    #1;
    chk("rd regrant s.ar_valid", 32'(s_if.ar_valid), 32'd1);
    chk("rd regrant s.ar_id", 32'(s_if.ar_id), 32'd0);
    tick();
    clear_inputs();

    // reset with three writes outstanding and a fourth waiting on the slave
    for (int i = 1; i <= 4; i++) begin
      m_if.aw_valid = 1'b1; m_if.aw_id = 6'(i);
      tick();
    end
    m_if.aw_valid = 1'b0; s_if.aw_ready = 1'b0;
    #1;
    chk("rst pre s.aw_valid", 32'(s_if.aw_valid), 32'd1);
    chk("rst pre s.aw_id", 32'(s_if.aw_id), 32'd3);
    chk("rst pre m.aw_ready", 32'(m_if.aw_ready), 32'd0);
    rstn = 1'b0;
    #1;
    chk("rst s.aw_valid", 32'(s_if.aw_valid), 32'd0);
    chk("rst m.aw_ready", 32'(m_if.aw_ready), 32'd1);
    tick();
    rstn = 1'b1; s_if.aw_ready = 1'b1;
    m_if.aw_valid = 1'b1; m_if.aw_id = 6'h3F;
    #1 chk("rst post m.aw_ready", 32'(m_if.aw_ready), 32'd1);
    tick();
    m_if.aw_valid = 1'b0;
    #1;
    chk("rst post s.aw_valid", 32'(s_if.aw_valid), 32'd1);
    chk("rst post s.aw_id", 32'(s_if.aw_id), 32'd0);
    tick();

    do_reset();
    random_phase(1500);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi_id_remapper.md
Name: axi_id_remapper

Overview:
- Connects an AXI master with a wide ID to a slave with a narrower ID, using dynamic ID allocation instead of truncation.
- Each distinct in-flight master ID gets a free slave ID. The full master ID is stored in a per-channel table and restored on the B and R responses.
- Unlike truncation, two master IDs that differ only in their upper bits never collide, so they are never needlessly serialised. Stalls happen only when the table is exhausted.
- Sits at the master side of an interconnect port, in place of a truncating downsizer where the master's ID usage is sparse.

Parameters:
- ACTIVE_CNT_WIDTH, 4: per-entry outstanding-transaction counter width. At most 2**ACTIVE_CNT_WIDTH-1 transactions are outstanding per entry.
- Derived, not settable: MID = master.ID_WIDTH, SID = slave.ID_WIDTH, NENT = 2**SID.
- Static check: $fatal(1, "Parameter mismatch") if any of the following holds:
  - any DATA/ADDR/USER width differs between master and slave;
  - MID <= SID.

Ports:
- clk  input  1  clock, shared with both interfaces
- rstn  input  1  asynchronous active-low reset
- master  axi_channel.slave  iface  upstream master, MID-bit IDs
- slave  axi_channel.master  iface  downstream slave, SID-bit IDs

Behaviour:
- Two independent, identical remap engines exist: write (AW/B) and read (AR/R).
- W passes straight through combinationally. All non-ID AW/AR/B/R fields pass through unchanged.
- Entry state, NENT entries per engine: mid[MID-1:0] and cnt[ACTIVE_CNT_WIDTH-1:0]. An entry is free when cnt == 0.
- Address stage (per engine): a one-entry holding register stg_valid/stg_req.
  - master.aw_ready = !stg_valid || slave handshake this cycle.
  - A request taken from master appears on slave.aw_valid one cycle later at the earliest. Latency is 1 cycle; back-to-back throughput is 1 per cycle when grants succeed.
- Grant logic, combinational from stg_req and the table:
  - hit: some entry has cnt != 0 and mid == stg id. Hits are unique by construction.
    - If hit and cnt != max: grant that entry index.
    - If hit and cnt == max: stall. Never allocate a second entry for the same ID, which preserves AXI same-ID ordering.
  - miss: grant the lowest-index free entry. If none is free, stall.
  - slave.aw_valid = stg_valid && grant; slave.aw_id = granted index.
  - slave.aw_valid must not depend on slave.aw_ready.
  - While stalled, the stage holds and master.aw_ready = 0.
- Table update on slave AW handshake: entry[idx].mid <= stg id; cnt += 1.
- Release:
  - Write engine: B handshake (slave.b_valid && b_ready) decrements entry[slave.b_id].cnt.
  - Read engine: decrement only on an R handshake with r_last = 1.
- Simultaneous increment and decrement on the same entry: cnt is unchanged and mid is rewritten with the same value.
- A freed entry (cnt 1->0) is allocatable from the next cycle, not the same cycle.
- Response path is combinational:
  - master.b_id = entry[slave.b_id].mid; master.r_id likewise.
  - valid/ready pass through.
- Out-of-protocol response: a response whose slave ID maps to an entry with cnt == 0 is a slave protocol error.
  - Forward it with the stale mid.
  - Do not decrement (saturate at 0).
  - Assertion fires in simulation.
- Reset (async, rstn low, including mid-burst):
  - All cnt and mid cleared to 0; stg_valid = 0.
  - master.aw_ready and master.ar_ready read 1 on release; slave.aw_valid and slave.ar_valid = 0.
  - Any in-flight transactions are abandoned.
- Reset output values: slave.aw_valid = slave.ar_valid = 0; master.aw_ready = master.ar_ready = 1. Pass-through outputs follow their inputs.

Test Plan:
Common configuration: MID = 6, SID = 2, ACTIVE_CNT_WIDTH = 2; slave always ready unless stated.
1. Distinct IDs: AW ids 0x00, 0x04, 0x08, 0x0C back-to-back -> slave ids 0, 1, 2, 3 on consecutive cycles. A fifth AW, id 0x10, stalls (master.aw_ready = 0) until the first B returns with b_id 0. It is then issued with slave id 0 one cycle after that B handshake. The B for it returns with master b_id 0x10.
2. Same ID: three AWs with id 0x21 -> all get slave id 0 and cnt reaches 3. A fourth with 0x21 stalls even though entries 1-3 are free. Releases after one B.
3. Read release: AR id 0x15 len 3 -> slave id 0. R beats 1-3 (r_last = 0) keep cnt = 1. The last beat returns master r_id 0x15 and frees the entry. A new AR id 0x2A is then granted slave id 0.
4. Simultaneous events: entry 0 at cnt = 1 with id 0x05. A new AW id 0x05 handshakes in the same cycle as the B for slave id 0 -> cnt stays 1. Next B frees the entry.
5. Reset mid-operation: with 3 writes outstanding, pulse rstn low for 1 cycle -> slave.aw_valid = 0 immediately. After release, an AW id 0x3F gets slave id 0 and aw_ready = 1.
6. Out-of-order slave: AW ids 0x01 (slave 0) and 0x02 (slave 1); slave returns B for id 1 first -> master sees b_id 0x02, then b_id 0x01.
